// File: rtl/pe_accum_adder.sv
// pe_accum_adder: joins NUM_IN operand channels and sums ACC_LEN transfers into one saturating or wrapping result.
// The result is registered one cycle after the final fire, and all in_ready bits stay low while a result is pending.
module pe_accum_adder #(
  parameter int DWIDTH   = 8,
  parameter int NUM_IN   = 2,
  parameter int ACC_LEN  = 4,
  parameter int OWIDTH   = 10,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [OWIDTH-1:0]        sum_data,
  output logic                     sum_ovf,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic                     busy
);

  localparam int WW = OWIDTH + $clog2(NUM_IN) + 1;
  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);
  localparam logic [WW-1:0] ACC_MAX  = {{(WW-OWIDTH){1'b0}}, {OWIDTH{1'b1}}};

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [OWIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]     cnt;
  logic              ovf_sticky;
  logic              step_ovf;
  logic              fire;
  logic              last;
  logic [WW-1:0]     step;
  logic [WW-1:0]     wide;

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (fire && last) state_nxt = S_OUT;
      S_OUT:   if (sum_valid && sum_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // Join: every lane sees the same ready, so no channel can handshake on its own.
  always_comb begin
    in_ready = '0;
    fire     = 1'b0;
    if (state == S_ACC) begin
      in_ready = {NUM_IN{&in_valid}};
      fire     = &in_valid;
    end
    busy = (cnt != '0) || (state == S_OUT);
  end

  always_comb begin
    step = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      step = step + WW'(in_data[i*DWIDTH +: DWIDTH]);
    end
    wide     = WW'(acc) + step;
    step_ovf = (wide > ACC_MAX);
    acc_nxt  = (step_ovf && SATURATE) ? {OWIDTH{1'b1}} : wide[OWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      sum_data   <= '0;
      sum_ovf    <= 1'b0;
      sum_valid  <= 1'b0;
    end else if (fire) begin
      if (last) begin
        sum_data   <= acc_nxt;
        sum_ovf    <= ovf_sticky | step_ovf;
        sum_valid  <= 1'b1;
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= acc_nxt;
        cnt        <= cnt + CW'(1);
        ovf_sticky <= ovf_sticky | step_ovf;
      end
    end else if (sum_valid && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_accum_adder.sv
// Bench for pe_accum_adder: a saturating and a wrapping instance share stimulus.
// A reference model pushes expected results that are popped on each output handshake.
module tb_pe_accum_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic        sum_ready;

  logic [1:0]  in_ready, in_ready_w;
  logic [9:0]  sum_data, sum_data_w;
  logic        sum_ovf, sum_ovf_w;
  logic        sum_valid, sum_valid_w;
  logic        busy, busy_w;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0] d;
    logic       o;
  } res_t;

  res_t q_s[$];
  res_t q_w[$];

  int m_acc_s, m_acc_w, m_cnt;
  bit m_ovf_s, m_ovf_w;

  always #5 clk = ~clk;

  pe_accum_adder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sum_data(sum_data), .sum_ovf(sum_ovf),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  pe_accum_adder #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .sum_data(sum_data_w), .sum_ovf(sum_ovf_w),
    .sum_valid(sum_valid_w), .sum_ready(sum_ready), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc_s = 0;
    m_acc_w = 0;
    m_cnt   = 0;
    m_ovf_s = 1'b0;
    m_ovf_w = 1'b0;
  endtask

  // One joined transfer; the model tracks both arithmetic modes.
  task automatic do_fire(input int a, input int b);
    res_t r;
    int   s;
    in_valid = 2'b11;
    in_data  = {8'(b), 8'(a)};
    #1;
    check("fire_in_ready", 32'(in_ready), 32'(2'b11));
    check("fire_no_result_yet", 32'(sum_valid), 32'd0);
    s = a + b;
    if (m_acc_s + s > 1023) begin
      m_acc_s = 1023;
      m_ovf_s = 1'b1;
    end else begin
      m_acc_s = m_acc_s + s;
    end
    if (m_acc_w + s > 1023) m_ovf_w = 1'b1;
    m_acc_w = (m_acc_w + s) % 1024;
    m_cnt++;
    if (m_cnt == 4) begin
      r.d = 10'(m_acc_s);
      r.o = m_ovf_s;
      q_s.push_back(r);
      r.d = 10'(m_acc_w);
      r.o = m_ovf_w;
      q_w.push_back(r);
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    in_data  = '0;
  endtask

  task automatic drain();
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    check("drain_valid_low", 32'(sum_valid), 32'd0);
    check("drain_busy_low", 32'(busy), 32'd0);
  endtask

  // Scoreboard: an output handshake with an empty queue compares against X and fails.
  always @(negedge clk) begin
    res_t e;
    if (reset === 1'b0 && sum_ready === 1'b1) begin
      if (sum_valid === 1'b1) begin
        e = (q_s.size() > 0) ? q_s.pop_front() : 'x;
        check("sb_sat_data", 32'(sum_data), 32'(e.d));
        check("sb_sat_ovf", 32'(sum_ovf), 32'(e.o));
      end
      if (sum_valid_w === 1'b1) begin
        e = (q_w.size() > 0) ? q_w.pop_front() : 'x;
        check("sb_wrap_data", 32'(sum_data_w), 32'(e.d));
        check("sb_wrap_ovf", 32'(sum_ovf_w), 32'(e.o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 2'b00;
    in_data   = '0;
    sum_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_sum_data", 32'(sum_data), 32'd0);
    check("rst_sum_ovf", 32'(sum_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Basic accumulation
    do_fire(1, 2);
    check("t1_busy", 32'(busy), 32'd1);
    do_fire(3, 4);
    do_fire(5, 6);
    do_fire(7, 8);
    check("t1_latency_valid", 32'(sum_valid), 32'd1);
    check("t1_sum_data", 32'(sum_data), 32'd36);
    check("t1_sum_ovf", 32'(sum_ovf), 32'd0);
    in_valid = 2'b11;
    #1;
    check("t1_in_ready_blocked", 32'(in_ready), 32'd0);
    in_valid = 2'b00;
    drain();

    // Join: a single valid lane must not fire
    in_valid = 2'b01;
    repeat (3) begin
      #1;
      check("t2_partial_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("t2_partial_busy", 32'(busy), 32'd0);
    end
    in_valid = 2'b00;
    do_fire(10, 20);
    check("t2_busy", 32'(busy), 32'd1);
    do_fire(0, 0);
    do_fire(0, 0);
    do_fire(0, 0);
    check("t2_sum_data", 32'(sum_data), 32'd30);
    drain();

    // Saturation and wrap
    repeat (4) do_fire(255, 255);
    check("t3_sat_data", 32'(sum_data), 32'd1023);
    check("t3_sat_ovf", 32'(sum_ovf), 32'd1);
    check("t4_wrap_data", 32'(sum_data_w), 32'd1016);
    check("t4_wrap_ovf", 32'(sum_ovf_w), 32'd1);
    drain();

    // Backpressure
    do_fire(1, 2);
    do_fire(3, 4);
    do_fire(5, 6);
    do_fire(7, 8);
    in_valid = 2'b11;
    in_data  = {8'd9, 8'd9};
    repeat (5) begin
      #1;
      check("t5_hold_valid", 32'(sum_valid), 32'd1);
      check("t5_hold_data", 32'(sum_data), 32'd36);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 2'b00;
    in_data   = '0;
    sum_ready = 1'b1;
    @(posedge clk);
    #1;
    sum_ready = 1'b0;
    check("t5_released", 32'(sum_valid), 32'd0);
    repeat (4) do_fire(1, 1);
    check("t5_next_data", 32'(sum_data), 32'd8);
    drain();

    // Reset mid-operation; inputs valid during reset must be ignored
    do_fire(100, 100);
    do_fire(100, 100);
    reset    = 1'b1;
    in_valid = 2'b11;
    in_data  = {8'd50, 8'd50};
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 2'b00;
    in_data  = '0;
    model_clear();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sum_valid", 32'(sum_valid), 32'd0);
    repeat (4) do_fire(1, 0);
    check("t6_sum_data", 32'(sum_data), 32'd4);
    check("t6_sum_ovf", 32'(sum_ovf), 32'd0);
    drain();

    check("sb_sat_empty", 32'(q_s.size()), 32'd0);
    check("sb_wrap_empty", 32'(q_w.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_accum_adder.md
Name: pe_accum_adder

Overview:
Parametrised successor to the two-operand PE adder.
- Joins NUM_IN operand channels and adds them each transfer.
- Accumulates ACC_LEN transfers into one result with selectable saturate or wrap arithmetic.
- Emits the result on a registered valid/ready output channel.
- Sits in the PE datapath between the multiplier/filter stages and the downstream partial-sum consumer, replacing chains of 2-input adders.

Parameters:
DWIDTH, 8, width of each unsigned input operand
NUM_IN, 2, number of input channels joined per transfer (>=1)
ACC_LEN, 4, number of joined transfers summed into one result (>=1)
OWIDTH, 10, width of the accumulator and the output result (>=DWIDTH)
SATURATE, 1, 1 = clamp to 2^OWIDTH-1 on overflow; 0 = wrap modulo 2^OWIDTH

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_data  input  NUM_IN*DWIDTH  operand i at bits [i*DWIDTH +: DWIDTH]
in_valid  input  NUM_IN  per-channel valid
in_ready  output  NUM_IN  per-channel ready
sum_data  output  OWIDTH  accumulated result
sum_ovf  output  1  high if any overflow occurred during this result
sum_valid  output  1  result valid
sum_ready  input  1  downstream ready
busy  output  1  high when at least one transfer has been accumulated or a result is pending

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=S_ACC, acc=0, cnt=0, ovf_sticky=0.
  - sum_valid=0, sum_data=0, sum_ovf=0, busy=0.
  - Any partial accumulation or pending result is discarded.
  - reset has priority over every other event in the same cycle.
- States: S_ACC (collect operands) and S_OUT (hold result).
- Join rule, all in_ready bits driven identically:
  - In S_ACC, in_ready[i] = &in_valid. This is combinational from in_valid; no channel handshakes alone.
  - In S_OUT, in_ready=0.
  - fire = (state==S_ACC) && &in_valid.
- Arithmetic on fire:
  - step = sum of all NUM_IN operands at full precision.
  - wide = acc + step, computed with at least OWIDTH+clog2(NUM_IN)+1 bits.
  - If wide > 2^OWIDTH-1, set ovf_sticky. Next acc = 2^OWIDTH-1 when SATURATE=1, else wide mod 2^OWIDTH.
  - Otherwise next acc = wide.
  - Once saturated, acc stays at max for the remaining transfers.
- Counting:
  - On a fire with cnt<ACC_LEN-1: cnt++, stay in S_ACC.
  - On a fire with cnt==ACC_LEN-1:
    - sum_data <= next acc, sum_ovf <= ovf_sticky | this step's overflow.
    - sum_valid <= 1, state <= S_OUT.
    - acc, cnt, ovf_sticky <= 0.
  - Latency: sum_valid rises the cycle after the final fire.
- S_OUT:
  - sum_data, sum_ovf and sum_valid are held stable until sum_valid && sum_ready.
  - On that handshake: sum_valid <= 0, state <= S_ACC.
  - The next fire is possible in the following cycle, so minimum period = ACC_LEN+1 cycles per result.
- busy = (cnt!=0) || (state==S_OUT).
- ACC_LEN=1: behaves as a registered NUM_IN-way adder with one bubble per result.
- NUM_IN=1: pure serial accumulator.
- in_data is ignored when fire=0. Invalid lanes never contribute.
- sum_ready is a don't-care while sum_valid=0.

Test Plan:
All tests use the defaults unless stated.
1. Basic accumulation: four fires with (1,2), (3,4), (5,6), (7,8) -> sum_valid one cycle after the 4th fire, sum_data=36, sum_ovf=0. in_ready=0 while sum_valid=1.
2. Join: in_valid=2'b01 held 3 cycles -> in_ready=00, no accumulation. Then in_valid=2'b11 with (10,20) -> single fire, internal acc=30. Completing with three fires of (0,0) yields sum_data=30.
3. Saturation: four fires of (255,255) -> after the 3rd fire acc=1023 with ovf set; final sum_data=1023, sum_ovf=1.
4. Wrap: same stimulus as test 3 with SATURATE=0 -> sum_data=2040 mod 1024=1016, sum_ovf=1.
5. Backpressure: result 36 pending with sum_ready=0 for 5 cycles -> sum_data/sum_valid stable and in_ready=00. Then sum_ready=1 for one cycle, and four fires of (1,1) -> next sum_data=8 (no carry-over).
6. Reset mid-operation: two fires of (100,100), then reset for 1 cycle -> busy=0, sum_valid=0. Four fires of (1,0) then produce sum_data=4, sum_ovf=0.
